fetch_stage: RTL and testbench

Instruction-fetch stage of each core's pipeline, directly upstream of decode and the control unit. It holds the PC, issues word reads to the instruction cache, and captures the returned instruction into the IF/ID latch. It drives the opcode and function fields the control unit decodes. It also applies stalls, flushes, branch/jump redirects and halt from downstream.

---
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Holds the PC, issues word reads to the
// instruction cache and captures returned words into the IF/ID latch. Applies
// redirect, flush, halt and stall from downstream, in that priority order.
//
// Optional feature macro: FETCH_SKID_EN. When defined, a word that hits while
// stall is high is parked in a one-entry skid buffer (state HOLD) instead of
// being discarded and re-fetched.
//
// Ports:
//   CLK, nRST            clock (rising edge), async active-low reset
//   imemload, ihit       icache return word and hit strobe
//   imemREN, imemaddr    read request and fetch address (= pc)
//   stall, flush         hold / squash IF/ID
//   redirect, redirect_pc  load pc from a resolved branch/jump target
//   halt                 stop fetching until reset
//   ifid_*               IF/ID latch: valid, instruction, pc, pc+4
//   op, funcop           opcode and funct fields of ifid_instr
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] imemload,
    input  logic        ihit,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc,
    output logic [5:0]  op,
    output logic [5:0]  funcop
);

    typedef enum logic [1:0] {StFetch, StHold, StHalted} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] npc_q, npc_d;

`ifdef FETCH_SKID_EN
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        npc_d   = npc_q;
`ifdef FETCH_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
`endif
        if (state_q == StHalted) begin
            // frozen until reset
        end else if (redirect || flush) begin
            // A squashed latch reads as all-zero so decode sees a NOP.
            if (redirect) begin
                pc_d = {redirect_pc[31:2], 2'b00};
            end
            valid_d = 1'b0;
            instr_d = '0;
            ipc_d   = '0;
            npc_d   = '0;
            state_d = StFetch;
`ifdef FETCH_SKID_EN
            skid_valid_d = 1'b0;
`endif
        end else if (halt) begin
            state_d = StHalted;
        end else if (state_q == StFetch) begin
            if (stall) begin
`ifdef FETCH_SKID_EN
                if (ihit) begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = imemload;
                    skid_pc_d    = pc_q;
                    state_d      = StHold;
                end
`endif
            end else if (ihit) begin
                valid_d = 1'b1;
                instr_d = imemload;
                ipc_d   = pc_q;
                npc_d   = pc_q + 32'd4;
                pc_d    = pc_q + 32'd4;
            end else begin
                valid_d = 1'b0;
                instr_d = '0;
                ipc_d   = '0;
                npc_d   = '0;
            end
        end
`ifdef FETCH_SKID_EN
        else if (state_q == StHold && !stall && skid_valid_q) begin
            valid_d      = 1'b1;
            instr_d      = skid_instr_q;
            ipc_d        = skid_pc_q;
            npc_d        = skid_pc_q + 32'd4;
            pc_d         = skid_pc_q + 32'd4;
            skid_valid_d = 1'b0;
            state_d      = StFetch;
        end
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StFetch;
            pc_q    <= {PC_INIT[31:2], 2'b00};
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            npc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            npc_q   <= npc_d;
        end
    end

`ifdef FETCH_SKID_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end
`endif

    // Gate with nRST so no request is issued while reset is held.
    assign imemREN    = nRST && (state_q == StFetch);
    assign imemaddr   = pc_q;
    assign ifid_valid = valid_q;
    assign ifid_instr = instr_q;
    assign ifid_pc    = ipc_q;
    assign ifid_npc   = npc_q;
    assign op         = instr_q[31:26];
    assign funcop     = instr_q[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] TbPcInit = 32'h0000_0100;
    localparam int ModeFetch  = 0;
    localparam int ModeHold   = 1;
    localparam int ModeHalted = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] imemload;
    logic        ihit;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall, flush, redirect, halt;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr, ifid_pc, ifid_npc;
    logic [5:0]  op, funcop;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural view of the stage.
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr, m_ipc, m_npc;
    logic [31:0] m_skid_instr[$];
    logic [31:0] m_skid_pc[$];
    bit          m_in_reset;

    fetch_stage #(.PC_INIT(TbPcInit)) dut (
        .CLK(CLK), .nRST(nRST), .imemload(imemload), .ihit(ihit),
        .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_npc(ifid_npc), .op(op), .funcop(funcop)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_bubble();
        m_valid = 1'b0;
        m_instr = 32'd0;
        m_ipc   = 32'd0;
        m_npc   = 32'd0;
    endfunction

    function automatic void m_reset();
        m_mode = ModeFetch;
        m_pc   = TbPcInit;
        m_bubble();
        m_skid_instr.delete();
        m_skid_pc.delete();
    endfunction

    function automatic void m_accept(input logic [31:0] w, input logic [31:0] at);
        m_valid = 1'b1;
        m_instr = w;
        m_ipc   = at;
        m_npc   = at + 32'd4;
        m_pc    = at + 32'd4;
    endfunction

    // One rising edge of the specified behaviour.
    function automatic void m_edge();
        if (m_mode == ModeHalted) return;
        if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_bubble();
            m_skid_instr.delete();
            m_skid_pc.delete();
            m_mode = ModeFetch;
        end else if (flush) begin
            m_bubble();
            m_skid_instr.delete();
            m_skid_pc.delete();
            m_mode = ModeFetch;
        end else if (halt) begin
            m_mode = ModeHalted;
        end else if (m_mode == ModeHold) begin
            if (!stall) begin
                m_accept(m_skid_instr.pop_front(), m_skid_pc.pop_front());
                m_mode = ModeFetch;
            end
        end else if (stall) begin
`ifdef FETCH_SKID_EN
            if (ihit) begin
                m_skid_instr.push_back(imemload);
                m_skid_pc.push_back(m_pc);
                m_mode = ModeHold;
            end
`endif
        end else if (ihit) begin
            m_accept(imemload, m_pc);
        end else begin
            m_bubble();
        end
    endfunction

    task automatic check_all();
        check_eq("imemREN", 32'(imemREN), 32'(!m_in_reset && m_mode == ModeFetch));
        check_eq("imemaddr", imemaddr, m_pc);
        check_eq("ifid_valid", 32'(ifid_valid), 32'(m_valid));
        check_eq("ifid_instr", ifid_instr, m_instr);
        check_eq("ifid_pc", ifid_pc, m_ipc);
        check_eq("ifid_npc", ifid_npc, m_npc);
        check_eq("op", 32'(op), 32'(m_instr >> 26));
        check_eq("funcop", 32'(funcop), m_instr & 32'h3F);
    endtask

    task automatic drive(input logic h, input logic [31:0] w, input logic s, input logic f,
                         input logic r, input logic [31:0] rpc, input logic hl);
        ihit = h; imemload = w; stall = s; flush = f; redirect = r;
        redirect_pc = rpc; halt = hl;
    endtask

    task automatic step();
        @(posedge CLK);
        m_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset away from the clock edge, released on a falling edge.
    task automatic pulse_reset();
        nRST = 1'b0;
        m_in_reset = 1'b1;
        #1;
        m_reset();
        check_all();
        @(negedge CLK);
        nRST = 1'b1;
        m_in_reset = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] addr0;
        drive(0, 0, 0, 0, 0, 0, 0);
        m_in_reset = 1'b0;
        nRST = 1'b1;
        #1;
        pulse_reset();
        check_eq("reset_addr", imemaddr, 32'h0000_0100);

        // Streaming fetch from PC_INIT.
        drive(1, 32'h2401_0005, 0, 0, 0, 0, 0);
        step();
        check_eq("first_instr", ifid_instr, 32'h2401_0005);
        check_eq("first_op", 32'(op), 32'h09);
        check_eq("first_npc", ifid_npc, 32'h0000_0104);
        check_eq("second_addr", imemaddr, 32'h0000_0104);
        for (int i = 0; i < 3; i++) begin
            imemload = $urandom;
            step();
        end

        // Stall 3 cycles with ihit high.
        addr0 = imemaddr;
        drive(1, 32'h8C22_0010, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
`ifdef FETCH_SKID_EN
        check_eq("hold_ren", 32'(imemREN), 32'd0);
`else
        check_eq("stall_addr_stable", imemaddr, addr0);
`endif
        stall = 1'b0;
        step();
        check_eq("post_stall_instr", ifid_instr, 32'h8C22_0010);
        check_eq("post_stall_pc", ifid_pc, addr0);

        // Redirect beats stall and ihit.
        drive(1, 32'h1234_5678, 1, 0, 1, 32'h0000_0200, 0);
        step();
        check_eq("redir_addr", imemaddr, 32'h0000_0200);
        check_eq("redir_valid", 32'(ifid_valid), 32'd0);
        check_eq("redir_op", 32'(op), 32'd0);

        // Wrap from top of the address space; low bits of target ignored.
        drive(1, 32'h0000_0021, 0, 0, 1, 32'hFFFF_FFFF, 0);
        step();
        check_eq("wrap_target", imemaddr, 32'hFFFF_FFFC);
        drive(1, 32'h0000_0021, 0, 0, 0, 0, 0);
        step();
        check_eq("wrap_addr", imemaddr, 32'h0000_0000);
        check_eq("wrap_npc", ifid_npc, 32'h0000_0000);

        // Halt: frozen for 10 cycles whatever the inputs.
        drive(1, 32'hFC00_0000, 0, 0, 0, 0, 1);
        step();
        check_eq("halt_ren", 32'(imemREN), 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, 1'($urandom));
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        pulse_reset();
        check_eq("restart_addr", imemaddr, TbPcInit);

`ifdef FETCH_SKID_EN
        // Reset with the skid buffer full.
        drive(1, 32'hAAAA_5555, 1, 0, 0, 0, 0);
        step();
        check_eq("skid_full", 32'(m_skid_pc.size()), 32'd1);
        check_eq("mid_hold_ren", 32'(imemREN), 32'd0);
        pulse_reset();
        drive(1, 32'h0000_0001, 0, 0, 0, 0, 0);
        step();
        check_eq("after_hold_reset_pc", ifid_pc, TbPcInit);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 40) == 0);
            if (m_mode == ModeHalted && $urandom_range(0, 7) == 0) begin
                pulse_reset();
            end else if ($urandom_range(0, 150) == 0) begin
                pulse_reset();
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
